// File: rtl/wb_ram_slave.sv
// Wishbone classic-cycle RAM slave with programmable wait states.
// Ports:
//   wb_clk_i, wb_rst_n_i        clock, asynchronous active-low reset
//   wb_cyc_i, wb_stb_i          request qualifiers (request = cyc & stb)
//   wb_we_i, wb_adr_i, wb_sel_i write enable, byte address, byte lanes
//   wb_dat_i / wb_dat_o         write data / registered read data
//   wb_ack_o, wb_err_o          registered one-cycle terminations
//   wb_rty_o                    tied low
module wb_ram_slave #(
  parameter int unsigned AW          = 10,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned DECODE_HI   = 27
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = 4;

  if (WAIT_STATES > 15) begin : g_bad_wait_states
    $error("wb_ram_slave: WAIT_STATES must be in 0..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DECODE_HI:2] adr_q, adr_d;
  logic               we_q, we_d;
  logic [3:0]         sel_q, sel_d;
  logic [31:0]        wdat_q, wdat_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [31:0]        dat_q, dat_d;

  logic [31:0]        mem [DEPTH];

  logic               req;
  logic               eval;
  logic               eval_bad;
  logic [DECODE_HI:2] eval_adr;
  logic               eval_we;
  logic [3:0]         eval_sel;
  logic [31:0]        eval_dat;
  logic [AW-1:0]      eval_idx;
  logic               ram_we;
  logic               unused_adr;

  assign req        = wb_cyc_i & wb_stb_i;
  assign unused_adr = ^{wb_adr_i[1:0], wb_adr_i[31:DECODE_HI+1]};

  // With zero wait states the request is resolved on its capture edge, so
  // evaluate the live bus; otherwise use the captured copy.
  always_comb begin
    if (state_q == S_IDLE) begin
      eval_adr = wb_adr_i[DECODE_HI:2];
      eval_we  = wb_we_i;
      eval_sel = wb_sel_i;
      eval_dat = wb_dat_i;
    end else begin
      eval_adr = adr_q;
      eval_we  = we_q;
      eval_sel = sel_q;
      eval_dat = wdat_q;
    end
  end

  assign eval_idx = eval_adr[AW+1:2];
  assign eval_bad = (eval_adr[DECODE_HI:AW+2] != '0) || (eval_sel == 4'b0000);

  // Edge that enters RESP: last wait cycle, or capture edge when no waits.
  assign eval = req &&
                (((state_q == S_IDLE) && (WAIT_STATES == 0)) ||
                 ((state_q == S_WAIT) && (cnt_q == CW'(1))));

  // Write commits on the ACK edge only; reset blocks it.
  assign ram_we = eval && !eval_bad && eval_we && wb_rst_n_i;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          adr_d   = wb_adr_i[DECODE_HI:2];
          we_d    = wb_we_i;
          sel_d   = wb_sel_i;
          wdat_d  = wb_dat_i;
          cnt_d   = CW'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        // Request is deliberately not sampled here.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (eval) begin
      if (eval_bad) begin
        err_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        if (!eval_we) begin
          dat_d = mem[eval_idx];
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // Byte-lane RAM write; contents are not reset.
  always_ff @(posedge wb_clk_i) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (eval_sel[b]) begin
          mem[eval_idx][8*b +: 8] <= eval_dat[8*b +: 8];
        end
      end
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Bench for wb_ram_slave: three instances (1, 3 and 0 wait states) driven by
// directed transfers, with a transaction-level model checked every cycle.
module tb_wb_ram_slave;

  logic        clk;
  logic        rst_n;
  logic        cyc   [3];
  logic        stb   [3];
  logic        we    [3];
  logic [31:0] adr   [3];
  logic [3:0]  sel   [3];
  logic [31:0] dat_i [3];
  logic [31:0] dat_o [3];
  logic        ack   [3];
  logic        err   [3];
  logic        rty   [3];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_ram_slave #(.AW(10), .WAIT_STATES(1), .DECODE_HI(27)) u_ws1 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
    .wb_we_i(we[0]), .wb_adr_i(adr[0]), .wb_sel_i(sel[0]), .wb_dat_i(dat_i[0]),
    .wb_dat_o(dat_o[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]), .wb_rty_o(rty[0]));

  wb_ram_slave #(.AW(10), .WAIT_STATES(3), .DECODE_HI(27)) u_ws3 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
    .wb_we_i(we[1]), .wb_adr_i(adr[1]), .wb_sel_i(sel[1]), .wb_dat_i(dat_i[1]),
    .wb_dat_o(dat_o[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]), .wb_rty_o(rty[1]));

  wb_ram_slave #(.AW(10), .WAIT_STATES(0), .DECODE_HI(27)) u_ws0 (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]),
    .wb_we_i(we[2]), .wb_adr_i(adr[2]), .wb_sel_i(sel[2]), .wb_dat_i(dat_i[2]),
    .wb_dat_o(dat_o[2]), .wb_ack_o(ack[2]), .wb_err_o(err[2]), .wb_rty_o(rty[2]));

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- transaction-level model ----------------
  // A request accepted at edge E terminates at edge E+ws unless it is seen
  // low before then; the edge after a termination accepts nothing.
  int          ws_of [3] = '{1, 3, 0};
  logic [31:0] mem_m [3][1024];
  bit          busy_m [3];
  int          deadline_m [3];
  logic        c_we [3];
  logic [31:0] c_adr [3];
  logic [3:0]  c_sel [3];
  logic [31:0] c_dat [3];
  logic        exp_ack [3];
  logic        exp_err [3];
  logic [31:0] exp_dat [3];
  int          edge_no = 0;

  function automatic void respond(input int k, input logic w, input logic [31:0] a,
                                  input logic [3:0] s, input logic [31:0] d);
    logic [15:0] hi;
    hi = a[27:12];
    if (hi != 16'h0 || s == 4'b0000) begin
      exp_err[k] = 1'b1;
    end else begin
      exp_ack[k] = 1'b1;
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) mem_m[k][a[11:2]][8*b +: 8] = d[8*b +: 8];
      end else begin
        exp_dat[k] = mem_m[k][a[11:2]];
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit req, was_resp;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        busy_m[k] = 1'b0; exp_ack[k] = 1'b0; exp_err[k] = 1'b0; exp_dat[k] = 32'h0;
      end
    end else begin
      edge_no++;
      for (int k = 0; k < 3; k++) begin
        req      = cyc[k] & stb[k];
        was_resp = exp_ack[k] | exp_err[k];
        exp_ack[k] = 1'b0;
        exp_err[k] = 1'b0;
        if (busy_m[k]) begin
          if (!req) busy_m[k] = 1'b0;
          else if (edge_no == deadline_m[k]) begin
            busy_m[k] = 1'b0;
            respond(k, c_we[k], c_adr[k], c_sel[k], c_dat[k]);
          end
        end else if (!was_resp && req) begin
          if (ws_of[k] == 0) respond(k, we[k], adr[k], sel[k], dat_i[k]);
          else begin
            busy_m[k] = 1'b1;
            deadline_m[k] = edge_no + ws_of[k];
            c_we[k] = we[k]; c_adr[k] = adr[k]; c_sel[k] = sel[k]; c_dat[k] = dat_i[k];
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ack[%0d]", k), 32'(ack[k]), 32'(exp_ack[k]));
      chk($sformatf("err[%0d]", k), 32'(err[k]), 32'(exp_err[k]));
      chk($sformatf("dat[%0d]", k), dat_o[k], exp_dat[k]);
      chk($sformatf("rty[%0d]", k), 32'(rty[k]), 32'h0);
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after a rising edge with the bus idle.
  task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input bit hold,
                      output logic got_ack, output logic got_err, output logic [31:0] rd,
                      output int lat, output logic after);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; sel[k] = s; dat_i[k] = d;
    lat = 0; got_ack = 1'b0; got_err = 1'b0; after = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      lat++;
      if (ack[k] || err[k]) break;
    end
    got_ack = ack[k]; got_err = err[k]; rd = dat_o[k];
    if (!(got_ack || got_err)) begin
      errors++;
      $display("FAIL timeout[%0d]: no termination within %0d cycles", k, lat);
    end
    if (hold) begin
      @(posedge clk); #1;
      after = ack[k] | err[k];
    end
    cyc[k] = 1'b0; stb[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  logic        ga, ge, af;
  logic [31:0] rd;
  int          lat;

  initial begin
    for (int k = 0; k < 3; k++) begin
      cyc[k] = 0; stb[k] = 0; we[k] = 0; adr[k] = 0; sel[k] = 0; dat_i[k] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_ack", 32'(ack[0]), 32'h0);
    chk("reset_dat", dat_o[0], 32'h0);

    // Basic write/read, STB held through the ACK cycle.
    xfer(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 1, ga, ge, rd, lat, af);
    chk("wr_ack", 32'(ga), 32'h1);
    chk("wr_lat", 32'(lat), 32'd2);
    chk("wr_pulse", 32'(af), 32'h0);
    xfer(0, 0, 32'h10, 4'hF, 32'h0, 1, ga, ge, rd, lat, af);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_lat", 32'(lat), 32'd2);
    chk("rd_pulse", 32'(af), 32'h0);

    // Byte lanes.
    xfer(0, 1, 32'h20, 4'hF, 32'h11223344, 0, ga, ge, rd, lat, af);
    xfer(0, 1, 32'h20, 4'b0101, 32'hAABBCCDD, 0, ga, ge, rd, lat, af);
    xfer(0, 0, 32'h20, 4'hF, 32'h0, 0, ga, ge, rd, lat, af);
    chk("lane_data", rd, 32'h11BB33DD);

    // Out of range read and empty-sel write.
    xfer(0, 0, 32'h1000, 4'hF, 32'h0, 0, ga, ge, rd, lat, af);
    chk("oor_err", 32'(ge), 32'h1);
    chk("oor_noack", 32'(ga), 32'h0);
    chk("oor_dat_kept", rd, 32'h11BB33DD);
    xfer(0, 1, 32'h20, 4'h0, 32'hFFFFFFFF, 0, ga, ge, rd, lat, af);
    chk("sel0_err", 32'(ge), 32'h1);
    xfer(0, 0, 32'h20, 4'hF, 32'h0, 0, ga, ge, rd, lat, af);
    chk("sel0_unchanged", rd, 32'h11BB33DD);

    // Abort on the 3-wait-state instance.
    xfer(1, 1, 32'h4, 4'hF, 32'hCAFEF00D, 0, ga, ge, rd, lat, af);
    chk("ws3_lat", 32'(lat), 32'd4);
    cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 32'h4; sel[1] = 4'hF; dat_i[1] = 32'h12345678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    stb[1] = 0;
    ga = 0;
    repeat (8) begin
      @(posedge clk); #1;
      ga = ga | ack[1] | err[1];
    end
    cyc[1] = 0;
    chk("abort_noterm", 32'(ga), 32'h0);
    xfer(1, 0, 32'h4, 4'hF, 32'h0, 0, ga, ge, rd, lat, af);
    chk("abort_old_data", rd, 32'hCAFEF00D);

    // Reset while waiting.
    cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 32'h10; sel[0] = 4'hF;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_ack", 32'(ack[0]), 32'h0);
    chk("rst_dat", dat_o[0], 32'h0);
    cyc[0] = 0; stb[0] = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    xfer(0, 0, 32'h10, 4'hF, 32'h0, 0, ga, ge, rd, lat, af);
    chk("post_rst_lat", 32'(lat), 32'd2);
    chk("post_rst_data", rd, 32'hDEADBEEF);

    // Zero-wait streaming.
    for (int i = 0; i < 8; i++) begin
      xfer(2, 1, 32'h100 + 32'(4*i), 4'hF, 32'h5A000000 + 32'(i) * 32'h01010101, 0,
           ga, ge, rd, lat, af);
      chk($sformatf("ws0_wr_lat%0d", i), 32'(lat), 32'd1);
    end
    begin
      int n_ack, last_t, extra;
      n_ack = 0; last_t = 0; extra = 0;
      cyc[2] = 1; stb[2] = 1; we[2] = 0; sel[2] = 4'hF; adr[2] = 32'h100;
      for (int t = 0; t < 40 && n_ack < 8; t++) begin
        @(posedge clk); #1;
        if (ack[2]) begin
          chk($sformatf("stream_dat%0d", n_ack), dat_o[2],
              32'h5A000000 + 32'(n_ack) * 32'h01010101);
          if (n_ack > 0) chk($sformatf("stream_gap%0d", n_ack), 32'(t - last_t), 32'd2);
          last_t = t;
          n_ack++;
          adr[2] = 32'h100 + 32'(4*n_ack);
        end
      end
      cyc[2] = 0; stb[2] = 0;
      repeat (4) begin
        @(posedge clk); #1;
        if (ack[2]) extra++;
      end
      chk("stream_count", 32'(n_ack + extra), 32'd8);
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
